// File: rtl/mb_seq_mult.sv
// Iterative radix-4 Modified Booth multiplier that retires one Booth digit per clock.
// Optional accumulate-on-done feature: define MB_ACC_EN.
module mb_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  input  logic               acc_clr
);

  localparam int unsigned EW   = WIDTH + 2;
  localparam int unsigned SW   = 2 * WIDTH + 2;
  localparam int unsigned D    = WIDTH / 2 + 1;
  localparam int unsigned CW   = $clog2(D + 1);
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("mb_seq_mult: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] out_p_q;
  logic [CW-1:0]      cnt_q;
  logic [SW-1:0]      a_q;
  logic [EW:0]        b_q;
  logic [SW-1:0]      sum_q;
  logic [SW-1:0]      sum_d;

  logic               sa, sb;
  logic [SW-1:0]      a_ext;
  logic [EW:0]        b_ext;
  logic [2:0]         digit;
  logic               one, two, neg;
  logic [SW-1:0]      pp, pp_x;
  logic [2*WIDTH-1:0] result;

  assign sa    = in_signed & in_a[WIDTH-1];
  assign sb    = in_signed & in_b[WIDTH-1];
  assign a_ext = {{(SW-WIDTH){sa}}, in_a};
  // b carries the implicit b[-1]=0 in bit 0 and shifts right two bits per digit
  assign b_ext = {{2{sb}}, in_b, 1'b0};

  // a_q is pre-shifted by 2i, so ~pp + neg is exactly -(PP << 2i)
  always_comb begin
    digit = b_q[2:0];
    one   = digit[0] ^ digit[1];
    two   = (digit == 3'b011) || (digit == 3'b100);
    neg   = digit[2] & ~(digit[1] & digit[0]);
    pp    = '0;
    if (two)      pp = {a_q[SW-2:0], 1'b0};
    else if (one) pp = a_q;
    pp_x  = neg ? ~pp : pp;
    sum_d = sum_q + pp_x + {{(SW-1){1'b0}}, neg};
  end

`ifdef MB_ACC_EN
  logic [2*WIDTH-1:0] acc_q;

  assign result = acc_q + sum_d[2*WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (state_q == IDLE && acc_clr) begin
      acc_q <= '0;
    end else if (state_q == CALC && cnt_q == LAST) begin
      acc_q <= result;
    end
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign result = sum_d[2*WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a_ext;
            b_q        <= b_ext;
            sum_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          sum_q <= sum_d;
          a_q   <= a_q << 2;
          b_q   <= b_q >> 2;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            out_p_q     <= result;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

endmodule

// File: tb/tb_mb_seq_mult.sv
// Self-checking bench for mb_seq_mult (WIDTH=8); define MB_ACC_EN to also exercise the accumulator.
module tb_mb_seq_mult;
  localparam int unsigned W = 8;
  localparam int          LAT = W / 2 + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_signed = 1'b0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           out_ready = 1'b0;
  logic           acc_clr = 1'b0;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] out_p;

  int             checks = 0;
  int             errors = 0;
  logic [2*W-1:0] acc_m = '0;

  mb_seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .acc_clr   (acc_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    int pa, pb;
    pa = s ? int'($signed(a)) : int'(a);
    pb = s ? int'($signed(b)) : int'(b);
    return (2*W)'(pa * pb);
  endfunction

  // Reference for what out_p should show: the product, or the running sum when accumulating.
  task automatic model_result(input logic [2*W-1:0] prod, input logic clr,
                              output logic [2*W-1:0] expv);
    if (clr) acc_m = '0;
    acc_m = acc_m + prod;
`ifdef MB_ACC_EN
    expv = acc_m;
`else
    expv = prod;
`endif
  endtask

  // Drives one operation end to end; returns the product seen and edges from accept to out_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic clr, output logic [2*W-1:0] p, output int lat);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_signed = s; acc_clr = clr; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; acc_clr = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_signed = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    p = out_p;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    acc_m = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_p=%h, required 1 0 0000",
               in_ready, out_valid, out_p);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [W-1:0]   ta [7] = '{8'h7E, 8'h7E, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00};
    logic [W-1:0]   tb [7] = '{8'hBD, 8'hBD, 8'hFF, 8'hFF, 8'h80, 8'hAB, 8'hAB};
    logic           ts [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2*W-1:0] tp [7] = '{16'h5D06, 16'hDF06, 16'hFE01, 16'h0001, 16'h4000, 16'h0000, 16'h0000};
    logic [2*W-1:0] p, expv;
    int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], ts[i], 1'b0, p, lat);
      model_result(tp[i], 1'b0, expv);
      checks++;
      if (p !== expv) begin
        errors++;
        $display("FAIL vector%0d: a=%h b=%h s=%b out_p=%h, required %h", i, ta[i], tb[i], ts[i], p, expv);
      end
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL latency%0d: got %0d edges, required %0d", i, lat, LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2*W-1:0] snap, expv;
    int n;
    @(negedge clk);
    in_a = 8'h7E; in_b = 8'h03; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    model_result(ref_prod(8'h7E, 8'h03, 1'b0), 1'b0, expv);
    snap = out_p;
    checks++;
    if (snap !== expv) begin
      errors++;
      $display("FAIL bp_result: out_p=%h, required %h", snap, expv);
    end
    in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_p !== snap || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b out_p=%h in_ready=%b, required 1 %h 0",
                 c, out_valid, out_p, in_ready, snap);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] p, expv;
    int lat;
    @(negedge clk);
    in_a = 8'h12; in_b = 8'h34; in_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    acc_m = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_p !== '0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b out_p=%h, required 0 1 0000",
               out_valid, in_ready, out_p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h03, 8'h05, 1'b0, 1'b0, p, lat);
    model_result(16'h000F, 1'b0, expv);
    checks++;
    if (p !== expv) begin
      errors++;
      $display("FAIL after_reset: out_p=%h, required %h", p, expv);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   a, b;
    logic           s;
    logic [2*W-1:0] expv;
    int seen [3];
    int k, e;
    a = W'($urandom); b = W'($urandom); s = 1'($urandom);
    @(negedge clk);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b1;
    k = 0; e = 0;
    while (k < 3 && e < 60) begin
      @(posedge clk); #1;
      e++;
      if (out_valid) begin
        seen[k] = e;
        model_result(ref_prod(a, b, s), 1'b0, expv);
        checks++;
        if (out_p !== expv) begin
          errors++;
          $display("FAIL b2b_result%0d: out_p=%h, required %h", k, out_p, expv);
        end
        k++;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL b2b_count: %0d results, required 3", k);
    end else begin
      // One IDLE accept cycle, D CALC cycles and one DONE cycle per operation
      checks++;
      if (seen[1] - seen[0] !== LAT + 2 || seen[2] - seen[1] !== LAT + 2) begin
        errors++;
        $display("FAIL b2b_period: %0d and %0d edges, required %0d", seen[1] - seen[0],
                 seen[2] - seen[1], LAT + 2);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0]   a, b;
    logic           s, clr;
    logic [2*W-1:0] p, expv;
    int lat;
    for (int i = 0; i < 1500; i++) begin
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      clr = ($urandom_range(7) == 0);
      do_op(a, b, s, clr, p, lat);
      model_result(ref_prod(a, b, s), clr, expv);
      checks++;
      if (p !== expv || lat !== LAT) begin
        errors++;
        $display("FAIL random%0d: a=%h b=%h s=%b out_p=%h lat=%0d, required %h lat=%0d",
                 i, a, b, s, p, lat, expv, LAT);
      end
    end
  endtask

`ifdef MB_ACC_EN
  task automatic test_acc();
    logic [2*W-1:0] p;
    int lat;
    do_op(8'h10, 8'h10, 1'b0, 1'b1, p, lat);
    checks++;
    if (p !== 16'h0100) begin
      errors++;
      $display("FAIL acc_first: out_p=%h, required 0100", p);
    end
    do_op(8'hFF, 8'h01, 1'b1, 1'b0, p, lat);
    checks++;
    if (p !== 16'h00FF) begin
      errors++;
      $display("FAIL acc_second: out_p=%h, required 00ff", p);
    end
    acc_m = 16'h00FF;
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef MB_ACC_EN
    test_acc();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
